// File: rtl/debounce_bank.sv
// ============================================================================
// Module   : debounce_bank
// Brief    : Multi-channel button/switch debouncer with polarity mapping,
//            2-FF synchronisers, edge pulses and optional long-press pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bank #(
    parameter int              N_CH        = 4,
    parameter int              THRESHOLD   = 500000,
    parameter int              HOLD_CYCLES = 0,
    parameter logic [N_CH-1:0] ACTIVE_LOW  = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    localparam int                 C_CNT_W    = $clog2(THRESHOLD + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(THRESHOLD - 1);

    logic [N_CH-1:0] w_pol;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    assign w_pol = button_in ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pol;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [C_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_rise;
        logic               r_fall;

        // Any cycle of agreement restarts the count; the level flips on the
        // THRESHOLD-th consecutive disagreeing cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (r_sync2[i] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2[i];
                    r_rise  <= r_sync2[i];
                    r_fall  <= ~r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end

        assign level[i] = r_level;
        assign rise[i]  = r_rise;
        assign fall[i]  = r_fall;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int                  C_HOLD_W    = $clog2(HOLD_CYCLES + 1);
            localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(HOLD_CYCLES);
            localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);

            logic [C_HOLD_W-1:0] r_hold;
            logic                r_long;

            // Hold count saturates so one press yields at most one pulse.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else if (!r_level) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else if (r_hold != C_HOLD_MAX) begin
                    r_hold <= r_hold + C_HOLD_W'(1);
                    r_long <= (r_hold == C_HOLD_LAST);
                end else begin
                    r_long <= 1'b0;
                end
            end

            assign long_press[i] = r_long;
        end else begin : g_no_hold
            assign long_press[i] = 1'b0;
        end
    end

endmodule

`default_nettype wire
